// File: rtl/fetch.sv
// Instruction fetch stage: one-cycle-latency imem requests feed a 2-entry
// {inst,pc} FIFO toward decode, with jump predecode and flush redirect.
module fetch (
    input  logic        clk,
    input  logic        rst,
    output logic [26:0] imem_addr,
    output logic        imem_re,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [26:0] pc,
    output logic        inst_valid,
    input  logic        n_stall,
    input  logic        dec_nstall,
    input  logic        flush,
    input  logic [26:0] redirect_pc
);

    logic [26:0] fpc_q, fpc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        infl_q, infl_d;
    logic        kill_q, kill_d;
    logic [26:0] ipc_q, ipc_d;
    logic [31:0] inst0_q, inst0_d, inst1_q, inst1_d;
    logic [26:0] pc0_q, pc0_d, pc1_q, pc1_d;

    logic        accept;
    logic        push;
    logic        issue;
    logic        jump;
    logic [2:0]  room;
    logic [1:0]  cnt_pop;

    assign inst_valid = (cnt_q != 2'd0);
    assign inst       = inst_valid ? inst0_q : 32'h0;
    assign pc         = inst_valid ? pc0_q : 27'h0;
    assign accept     = n_stall & dec_nstall & inst_valid;
    assign push       = infl_q & ~kill_q;

    // Occupancy left after this edge; issuing only below 2 guarantees the
    // response next cycle always finds a free slot.
    assign room      = {1'b0, cnt_q} + {2'b00, push} - {2'b00, accept};
    assign issue     = ~rst & ~flush & (room < 3'd2);
    assign imem_re   = issue;
    assign imem_addr = fpc_q;
    assign jump      = push & (imem_rdata[2:0] == 3'b111);
    assign cnt_pop   = cnt_q - {1'b0, accept};

    always_comb begin
        fpc_d   = fpc_q;
        cnt_d   = cnt_q;
        infl_d  = infl_q;
        kill_d  = kill_q;
        ipc_d   = ipc_q;
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        if (flush) begin
            cnt_d  = 2'd0;
            fpc_d  = {redirect_pc[26:2], 2'b00};
            infl_d = 1'b0;
            kill_d = 1'b1;
        end else begin
            if (accept) begin
                inst0_d = inst1_q;
                pc0_d   = pc1_q;
            end
            if (push) begin
                if (cnt_pop == 2'd0) begin
                    inst0_d = imem_rdata;
                    pc0_d   = ipc_q;
                end else begin
                    inst1_d = imem_rdata;
                    pc1_d   = ipc_q;
                end
            end
            cnt_d  = cnt_pop + {1'b0, push};
            infl_d = issue;
            // The sequential fetch issued alongside a jump push is on the wrong path.
            kill_d = jump & issue;
            if (issue) begin
                ipc_d = fpc_q;
            end
            if (jump) begin
                fpc_d = {imem_rdata[30:6], 2'b00};
            end else if (issue) begin
                fpc_d = fpc_q + 27'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q  <= 27'h0;
            cnt_q  <= 2'd0;
            infl_q <= 1'b0;
            kill_q <= 1'b0;
        end else begin
            fpc_q  <= fpc_d;
            cnt_q  <= cnt_d;
            infl_q <= infl_d;
            kill_q <= kill_d;
        end
    end

    // Payload registers need no reset: they are only observed through cnt_q.
    always_ff @(posedge clk) begin
        ipc_q   <= ipc_d;
        inst0_q <= inst0_d;
        inst1_q <= inst1_d;
        pc0_q   <= pc0_d;
        pc1_q   <= pc1_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !accept && !flush && cnt_q == 2'd2))
                else $error("fetch: push into full FIFO");
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios then randomized traffic,
// checked against a program-order model of which pc decode must see next.
module tb_fetch;

    logic        clk;
    logic        rst;
    logic [26:0] imem_addr;
    logic        imem_re;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [26:0] pc;
    logic        inst_valid;
    logic        n_stall;
    logic        dec_nstall;
    logic        flush;
    logic [26:0] redirect_pc;

    int          vectors = 0;
    int          miscompares = 0;
    int          starve = 0;
    logic        prev_re = 1'b0;
    logic [26:0] prev_addr = 27'h0;
    logic [26:0] exp_pc = 27'h0;
    logic        j10_en = 1'b0;
    logic        rj_en = 1'b0;

    fetch dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_re    (imem_re),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .inst_valid (inst_valid),
        .n_stall    (n_stall),
        .dec_nstall (dec_nstall),
        .flush      (flush),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem(input logic [26:0] a);
        logic [31:0] h;
        h = {5'd0, a} * 32'h9E3779B1 + 32'h01234567;
        if (j10_en && a == 27'h10) return {1'b0, 25'h40, 3'b000, 3'b111};
        if (rj_en && h[10:7] == 4'd5) return {h[31:3], 3'b111};
        return {h[31:1], 1'b0};
    endfunction

    // Program order: a jump word redirects to its encoded target, else pc+4.
    function automatic logic [26:0] next_pc(input logic [26:0] p);
        logic [31:0] w;
        w = mem(p);
        if (w[2:0] == 3'b111) return {w[30:6], 2'b00};
        return p + 27'd4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic ns, input logic dn,
                         input logic fl, input logic [26:0] rp);
        @(negedge clk);
        rst         = r;
        n_stall     = ns;
        dec_nstall  = dn;
        flush       = fl;
        redirect_pc = rp;
        if (prev_re) imem_rdata = mem(prev_addr);
        else         imem_rdata = $urandom;
        #1;
        if (r) begin
            chk("rst_valid", inst_valid, 0);
            chk("rst_inst", inst, 0);
            chk("rst_pc", pc, 0);
            chk("rst_re", imem_re, 0);
            chk("rst_addr", imem_addr, 0);
            exp_pc = 27'h0;
            starve = 0;
        end else begin
            chk("addr_align", {30'd0, imem_addr[1:0]}, 0);
            if (fl) chk("re_in_flush", imem_re, 0);
            if (inst_valid) begin
                chk("head_pc", pc, exp_pc);
                chk("head_inst", inst, mem(exp_pc));
                starve = 0;
            end else begin
                chk("bubble_inst", inst, 0);
                chk("bubble_pc", pc, 0);
                if (!fl) starve++;
                if (starve > 3) chk("liveness", inst_valid, 1);
            end
            if (fl) begin
                exp_pc = {rp[26:2], 2'b00};
                starve = 0;
            end else if (inst_valid && ns && dn) begin
                exp_pc = next_pc(exp_pc);
            end
        end
        prev_re   = imem_re;
        prev_addr = imem_addr;
    endtask

    task automatic to_valid();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
            if (inst_valid) return;
        end
        chk("wait_valid_timeout", inst_valid, 1);
    endtask

    initial begin
        logic [31:0] rv;
        logic        r, fl, ns, dn;
        int          n;
        rst = 1'b1; n_stall = 1'b0; dec_nstall = 1'b0; flush = 1'b0;
        redirect_pc = 27'h0; imem_rdata = 32'h0;

        // Reset, then steady fetch 0,4 from cycle 2
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 27'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 27'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("a_first_re", imem_re, 1);
        chk("a_first_addr", imem_addr, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("a_c1_valid", inst_valid, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("a_c2_valid", inst_valid, 1);
        chk("a_c2_pc", pc, 27'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("a_c3_valid", inst_valid, 1);
        chk("a_c3_pc", pc, 27'h4);

        // Stall three cycles with pc=8 at head
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 27'h0);
            chk("b_stall_valid", inst_valid, 1);
            chk("b_stall_pc", pc, 27'h8);
            chk("b_stall_re", imem_re, 0);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("b_resume_pc8", pc, 27'h8);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("b_resume_pc12", pc, 27'hC);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("b_resume_pc16", pc, 27'h10);

        // Flush to 0x100 while 0x20 is at the head
        n = 0;
        while (exp_pc != 27'h20 && n < 40) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
            n++;
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 27'h100);
        chk("c_flush_head_pc", pc, 27'h20);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("c_next_valid", inst_valid, 0);
        chk("c_next_addr", imem_addr, 27'h100);
        chk("c_next_re", imem_re, 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("c_n2_valid", inst_valid, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("c_n3_valid", inst_valid, 1);
        chk("c_n3_pc", pc, 27'h100);

        // Jump word at 0x10 targets 0x100
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 27'h8);
        j10_en = 1'b1;
        n = 0;
        while (exp_pc != 27'h10 && n < 40) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
            n++;
        end
        to_valid();
        chk("d_src_pc", pc, 27'h10);
        to_valid();
        chk("d_tgt_pc", pc, 27'h100);

        // Flush in the same cycle the jump word arrives
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 27'h8);
        n = 0;
        while (!(prev_re && prev_addr == 27'h10) && n < 40) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
            n++;
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 27'h200);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("e_addr", imem_addr, 27'h200);
        to_valid();
        chk("e_pc", pc, 27'h200);

        // Fill the FIFO, pulse reset, restart from 0
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 27'h0);
        j10_en = 1'b0;
        rj_en  = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 27'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("f_first_re", imem_re, 1);
        chk("f_first_addr", imem_addr, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("f_c1_valid", inst_valid, 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 27'h0);
        chk("f_c2_valid", inst_valid, 1);
        chk("f_c2_pc", pc, 27'h0);

        // Randomized stalls, flushes, resets and jumps
        for (int i = 0; i < 3000; i++) begin
            rv = $urandom;
            r  = ($urandom_range(0, 199) == 0);
            fl = !r && ($urandom_range(0, 19) == 0);
            ns = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            dn = ($urandom_range(0, 4) != 0);
            cycle(r, ns, dn, fl, {rv[26:2], 2'b00});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 imem_addr  output  27  byte address of instruction fetch; bits [1:0] always 0.
REQ-004 imem_re  output  1  fetch request strobe; one request per cycle at most.
REQ-005 imem_rdata  input  32  instruction word, valid exactly one cycle after the cycle imem_re was high.
REQ-006 inst  output  32  instruction presented to decode.
REQ-007 pc  output  27  byte address of inst.
REQ-008 inst_valid  output  1  inst/pc hold a real instruction; when low, inst = 32'h0 (bubble).
REQ-009 n_stall  input  1  pipeline advance enable; low = hold.
REQ-010 dec_nstall  input  1  decode hazard (load-use) release; low = hold.
REQ-011 flush  input  1  redirect request from branch resolution.
REQ-012 redirect_pc  input  27  branch target, valid when flush high.

Function
REQ-013 Internal state: fetch PC fpc (27b), 2-entry FIFO of {inst,pc}, in-flight flag with its pc, kill bit.
REQ-014 accept = n_stall & dec_nstall & inst_valid; on accept the FIFO head is popped at the clock edge.
REQ-015 inst/pc/inst_valid driven from FIFO head combinationally; when FIFO empty: inst=0, pc=0, inst_valid=0.
REQ-016 imem_addr = fpc at all times.
REQ-017 imem_re = 1 iff (occupancy + live_inflight - accept) < 2 and flush = 0; live_inflight = in-flight & ~kill.
REQ-018 On an issue, fpc <= fpc + 4 (mod 2^27, wraps 0x7FFFFFC -> 0); in-flight set, pc recorded, kill cleared.
REQ-019 Response arriving (in-flight set the previous cycle) and not killed is pushed to FIFO tail with its recorded pc, same edge as any pop.
REQ-020 Killed response is discarded; FIFO unchanged by it.
REQ-021 Jump predecode: pushed word with imem_rdata[2:0]=3'b111 sets fpc <= {imem_rdata[30:6],2'b00}; any request issued in that same cycle is marked killed.
REQ-022 Flush: FIFO cleared, fpc <= redirect_pc, current in-flight marked killed, no issue this cycle; first request to redirect_pc issued next cycle.
REQ-023 Flush has priority over jump predecode, push and pop in the same cycle.
REQ-024 Latency: redirect to first inst_valid with new pc = 2 cycles after flush edge.
REQ-025 FIFO never overflows; push into full FIFO is impossible by REQ-017 (assertion).
REQ-026 Simultaneous push and pop with occupancy 2 or 1: occupancy unchanged, order preserved.
REQ-027 Steady state (no stall, no redirect): one instruction accepted per cycle, pc incrementing by 4.
REQ-028 Stall (accept=0) holds inst/pc stable; fetch stops once FIFO + in-flight reach 2.

Reset
REQ-029 While rst high: fpc=0, FIFO empty, in-flight=0, kill=0, imem_re=0, inst=0, pc=0, inst_valid=0.
REQ-030 Reset asserted mid-operation discards all FIFO and in-flight state immediately; response arriving after release is ignored.
REQ-031 First cycle after rst deasserts: imem_re=1, imem_addr=0; inst_valid=1 with pc=0 two cycles after release.

Verification
REQ-032 Reset release, imem returns non-jump words, stalls never asserted -> pc sequence 0,4,8,12 on consecutive cycles, inst_valid continuously high from cycle 2.
REQ-033 n_stall low 3 cycles while pc=8 at head -> inst/pc held at pc=8, at most 2 words buffered, no imem_re once full, resume yields 8,12,16 without loss or duplication.
REQ-034 flush with redirect_pc=0x100 while pc=0x20 at head and request in flight -> next cycle inst_valid=0, imem_addr=0x100; two cycles later pc=0x100; old in-flight word never appears.
REQ-035 Word at pc=0x10 has [2:0]=111, [30:6]=0x40 -> pc=0x10 delivered, next delivered pc=0x100, pc=0x14 never delivered.
REQ-036 flush and jump push in same cycle, redirect_pc=0x200 -> next delivered pc=0x200, jump target ignored.
REQ-037 rst asserted for one cycle while FIFO full -> outputs zero immediately, restart from pc=0 per REQ-031.
